// File: rtl/router_fsm_nch_if.sv
// router_fsm_nch_if: source-side, FIFO-side and decode signals of the router FSM.
interface router_fsm_nch_if #(parameter int NUM_CH = 3, parameter int ADDR_W = 2);
    logic              pkt_valid;
    logic [ADDR_W-1:0] data_in;
    logic [NUM_CH-1:0] fifo_full;
    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] soft_reset;
    logic              parity_done;
    logic              low_packet_valid;
    logic              write_enb_reg;
    logic              detect_add;
    logic              ld_state;
    logic              laf_state;
    logic              lfd_state;
    logic              full_state;
    logic              rst_int_reg;
    logic              busy;
    logic              drop_state;
    logic [ADDR_W-1:0] cur_ch;
    logic              addr_err;
    logic              timeout_err;
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
        input  write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg,
               busy, drop_state, cur_ch, addr_err, timeout_err
    );
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_packet_valid,
        output write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg,
               busy, drop_state, cur_ch, addr_err, timeout_err
    );
endinterface

// File: rtl/router_fsm_nch.sv
// router_fsm_nch: packet router control FSM for NUM_CH output channels with wait timeout and address check.
module router_fsm_nch #(
    parameter int NUM_CH   = 3,
    parameter int ADDR_W   = 2,
    parameter int WAIT_MAX = 32
) (
    input logic clk,
    input logic resetn,
    router_fsm_nch_if.slave bus
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [8:0] {
        DECODE_ADDRESS     = 9'h001,
        WAIT_TILL_EMPTY    = 9'h002,
        LOAD_FIRST_DATA    = 9'h004,
        LOAD_DATA          = 9'h008,
        LOAD_PARITY        = 9'h010,
        FIFO_FULL_STATE    = 9'h020,
        LOAD_AFTER_FULL    = 9'h040,
        CHECK_PARITY_ERROR = 9'h080,
        DROP_PACKET        = 9'h100
    } state_t;

    state_t state, next;
    logic [ADDR_W-1:0] cur_ch;
    logic [CW-1:0] cnt;
    logic legal, sel_full, sel_empty, sel_sr;

    assign legal     = int'(bus.data_in) < NUM_CH;
    assign sel_full  = bus.fifo_full[cur_ch];
    assign sel_empty = bus.fifo_empty[cur_ch];
    assign sel_sr    = bus.soft_reset[cur_ch];

    always_comb begin
        next = state;
        case (state)
            DECODE_ADDRESS:     if (bus.pkt_valid) next = !legal ? DROP_PACKET :
                                    bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:    next = sel_empty ? LOAD_FIRST_DATA : (cnt == LAST) ? DROP_PACKET : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    next = LOAD_DATA;
            LOAD_DATA:          next = sel_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        next = CHECK_PARITY_ERROR;
            FIFO_FULL_STATE:    next = sel_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    next = bus.parity_done ? DECODE_ADDRESS : bus.low_packet_valid ? LOAD_PARITY : LOAD_DATA;
            CHECK_PARITY_ERROR: next = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            DROP_PACKET:        next = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
            default:            next = DECODE_ADDRESS;
        endcase
        // Soft reset of the active channel aborts any in-flight packet.
        if (sel_sr && state != DECODE_ADDRESS && state != DROP_PACKET) next = DECODE_ADDRESS;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= DECODE_ADDRESS;
            cur_ch          <= '0;
            cnt             <= '0;
            bus.addr_err    <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            state <= next;
            if (state == DECODE_ADDRESS && bus.pkt_valid && legal) cur_ch <= bus.data_in;
            cnt <= (state == WAIT_TILL_EMPTY && next == WAIT_TILL_EMPTY) ? cnt + 1'b1 : '0;
            bus.addr_err    <= state == DECODE_ADDRESS && next == DROP_PACKET;
            bus.timeout_err <= state == WAIT_TILL_EMPTY && next == DROP_PACKET;
        end
    end

    assign bus.cur_ch        = cur_ch;
    assign bus.write_enb_reg = state inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
    assign bus.detect_add    = state == DECODE_ADDRESS;
    assign bus.ld_state      = state == LOAD_DATA;
    assign bus.laf_state     = state == LOAD_AFTER_FULL;
    assign bus.lfd_state     = state == LOAD_FIRST_DATA;
    assign bus.full_state    = state == FIFO_FULL_STATE;
    assign bus.rst_int_reg   = state == CHECK_PARITY_ERROR;
    assign bus.drop_state    = state == DROP_PACKET;
    assign bus.busy          = !(state inside {DECODE_ADDRESS, LOAD_DATA, DROP_PACKET});
endmodule

// File: tb/tb_router_fsm_nch.sv
// tb_router_fsm_nch: two router FSMs (WAIT_MAX 4 and 7) driven identically and checked each cycle against a packet-level model.
module tb_router_fsm_nch;
    logic clk, resetn;
    logic pv, pd, lpv;
    logic [1:0] din;
    logic [2:0] ff, fe, sr;
    int n_cmp = 0, n_err = 0;

    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) b0 ();
    router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) b1 ();

    assign b0.pkt_valid = pv;  assign b1.pkt_valid = pv;
    assign b0.data_in = din;   assign b1.data_in = din;
    assign b0.fifo_full = ff;  assign b1.fifo_full = ff;
    assign b0.fifo_empty = fe; assign b1.fifo_empty = fe;
    assign b0.soft_reset = sr; assign b1.soft_reset = sr;
    assign b0.parity_done = pd; assign b1.parity_done = pd;
    assign b0.low_packet_valid = lpv; assign b1.low_packet_valid = lpv;

    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_MAX(4)) u0 (.clk(clk), .resetn(resetn), .bus(b0.slave));
    router_fsm_nch #(.NUM_CH(3), .ADDR_W(2), .WAIT_MAX(7)) u1 (.clk(clk), .resetn(resetn), .bus(b1.slave));

    logic [10:0] f0, f1;
    assign f0 = {b0.write_enb_reg, b0.detect_add, b0.ld_state, b0.laf_state, b0.lfd_state, b0.full_state,
                 b0.rst_int_reg, b0.busy, b0.drop_state, b0.addr_err, b0.timeout_err};
    assign f1 = {b1.write_enb_reg, b1.detect_add, b1.ld_state, b1.laf_state, b1.lfd_state, b1.full_state,
                 b1.rst_int_reg, b1.busy, b1.drop_state, b1.addr_err, b1.timeout_err};

    initial clk = 0;
    always #5 clk = ~clk;

    // Packet-phase model: one entry per DUT, WAIT_MAX taken from wm().
    typedef enum {M_DEC, M_WAIT, M_LFD, M_LD, M_LP, M_FFS, M_LAF, M_CPE, M_DROP} mst_t;
    mst_t m_st[2];
    int m_ch[2], m_cnt[2];
    bit m_ae[2], m_te[2];

    function automatic int wm(int k);
        return k == 0 ? 4 : 7;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_DEC; m_ch[k] = 0; m_cnt[k] = 0; m_ae[k] = 0; m_te[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            mst_t s = m_st[k], ns = m_st[k];
            int ch = m_ch[k];
            bit ae = 0, te = 0;
            case (s)
                M_DEC: if (pv) begin
                    if (din < 3) begin m_ch[k] = din; ns = fe[din] ? M_LFD : M_WAIT; end
                    else begin ns = M_DROP; ae = 1; end
                end
                M_WAIT: if (fe[ch]) ns = M_LFD;
                        else begin
                            m_cnt[k]++;
                            if (m_cnt[k] >= wm(k)) begin ns = M_DROP; te = 1; end
                        end
                M_LFD:  ns = M_LD;
                M_LD:   ns = ff[ch] ? M_FFS : (!pv ? M_LP : M_LD);
                M_LP:   ns = M_CPE;
                M_FFS:  ns = ff[ch] ? M_FFS : M_LAF;
                M_LAF:  ns = pd ? M_DEC : (lpv ? M_LP : M_LD);
                M_CPE:  ns = ff[ch] ? M_FFS : M_DEC;
                M_DROP: ns = pv ? M_DROP : M_DEC;
            endcase
            if (s != M_DEC && s != M_DROP && sr[ch]) begin ns = M_DEC; te = 0; end
            if (ns == M_WAIT && s != M_WAIT) m_cnt[k] = 0;
            m_st[k] = ns; m_ae[k] = ae; m_te[k] = te;
        end
    endtask

    function automatic logic [10:0] exp_flags(int k);
        mst_t s = m_st[k];
        return {s inside {M_LD, M_LP, M_LAF}, s == M_DEC, s == M_LD, s == M_LAF, s == M_LFD, s == M_FFS,
                s == M_CPE, !(s inside {M_DEC, M_LD, M_DROP}), s == M_DROP, m_ae[k], m_te[k]};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("flags_wm4", 32'(f0), 32'(exp_flags(0)));
        chk("cur_ch_wm4", 32'(b0.cur_ch), 32'(m_ch[0]));
        chk("flags_wm7", 32'(f1), 32'(exp_flags(1)));
        chk("cur_ch_wm7", 32'(b1.cur_ch), 32'(m_ch[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        pv = 0; din = 0; ff = 0; fe = 3'b111; sr = 0; pd = 0; lpv = 0;
    endtask

    task automatic drain();
        idle();
        repeat (6) step();
    endtask

    task automatic do_reset();
        resetn = 0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        resetn = 1;
    endtask

    initial begin
        idle();
        resetn = 0;
        model_reset();
        @(negedge clk);
        check_all();
        resetn = 1;

        // Clean packet to channel 1
        pv = 1; din = 1; step();
        din = 2; repeat (5) step();
        pv = 0; repeat (3) step();
        chk("ch_after_pkt", 32'(b0.cur_ch), 32'd1);

        // Channel 2 busy for a while; channel 0 empty bit toggles
        pv = 1; din = 2; fe = 3'b011; step();
        repeat (5) begin fe[0] = ~fe[0]; step(); end
        fe[2] = 1; step();
        drain();

        // Channel 0 never drains: timeout
        pv = 1; din = 0; fe = 3'b110; repeat (10) step();
        pv = 0; step();
        drain();

        // Illegal address
        pv = 1; din = 3; repeat (3) step();
        pv = 0; step();
        drain();

        // Full during load on channel 1, others' full bits pulsing
        pv = 1; din = 1; step(); step();
        ff = 3'b010; repeat (3) begin ff[0] = ~ff[0]; ff[2] = ~ff[2]; step(); end
        ff = 0; step();
        step();
        ff = 3'b010; step(); step();
        ff = 0; lpv = 1; step(); step();
        drain();

        // Soft reset: foreign channel ignored, own channel aborts
        pv = 1; din = 1; step(); step();
        ff = 3'b010; step();
        sr = 3'b100; step();
        sr = 3'b010; step();
        drain();

        // Async reset mid-load
        pv = 1; din = 2; step(); step(); step();
        do_reset();
        chk("ch_after_reset", 32'(b1.cur_ch), 32'd0);
        drain();

        repeat (3000) begin
            pv  = $urandom_range(0, 3) != 0;
            din = 2'($urandom_range(0, 3));
            ff  = 3'($urandom) & 3'($urandom);
            fe  = 3'($urandom) | 3'($urandom);
            sr  = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
            pd  = $urandom_range(0, 3) == 0;
            lpv = $urandom_range(0, 3) == 0;
            if ($urandom_range(0, 299) == 0) do_reset();
            else step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/router_fsm_nch.md
ROUTER_FSM_NCH -- requirements
Module: router_fsm_nch

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of output channels (legal 2..8).
REQ-002 SHALL have parameter ADDR_W, default 2, width of header address field (2^ADDR_W >= NUM_CH).
REQ-003 SHALL have parameter WAIT_MAX, default 32, max cycles spent in WAIT_TILL_EMPTY before timeout (legal 1..1023).
REQ-004 SHALL have one clock and an asynchronous, active-low reset, named clk and resetn.
REQ-005 Ports (name direction width meaning):
  clk  in  1  rising-edge clock
  resetn  in  1  async active-low reset
  pkt_valid  in  1  source packet valid
  data_in  in  ADDR_W  header address field (meaningful in DECODE_ADDRESS only)
  fifo_full  in  NUM_CH  per-channel FIFO full
  fifo_empty  in  NUM_CH  per-channel FIFO empty
  soft_reset  in  NUM_CH  per-channel soft reset from output side
  parity_done  in  1  parity byte written
  low_packet_valid  in  1  pkt_valid fell while full
  write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state, rst_int_reg, busy, drop_state  out  1 each  state decodes
  cur_ch  out  ADDR_W  latched destination channel
  addr_err  out  1  one-cycle pulse: illegal address
  timeout_err  out  1  one-cycle pulse: wait timeout

Function
REQ-006 States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, CHECK_PARITY_ERROR, DROP_PACKET; one-hot encoded, registered.
REQ-007 DECODE_ADDRESS: pkt_valid & data_in<NUM_CH -> latch cur_ch=data_in; fifo_empty[data_in] -> LOAD_FIRST_DATA else WAIT_TILL_EMPTY; pkt_valid & data_in>=NUM_CH -> DROP_PACKET, addr_err=1 next cycle for exactly one cycle; no pkt_valid -> stay.
REQ-008 WAIT_TILL_EMPTY: only fifo_empty[cur_ch] evaluated; empty -> LOAD_FIRST_DATA; else wait counter increments; counter reaching WAIT_MAX with channel still not empty -> DROP_PACKET, timeout_err one-cycle pulse; empty on the timeout cycle wins (-> LOAD_FIRST_DATA, no pulse).
REQ-009 Wait counter cleared on every entry to WAIT_TILL_EMPTY; width ceil(log2(WAIT_MAX+1)); never wraps.
REQ-010 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-011 LOAD_DATA: fifo_full[cur_ch] -> FIFO_FULL_STATE (priority); else ~pkt_valid -> LOAD_PARITY; else stay.
REQ-012 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-013 FIFO_FULL_STATE: stay while fifo_full[cur_ch]; else -> LOAD_AFTER_FULL.
REQ-014 LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_packet_valid -> LOAD_PARITY; else LOAD_DATA.
REQ-015 CHECK_PARITY_ERROR: fifo_full[cur_ch] -> FIFO_FULL_STATE; else DECODE_ADDRESS.
REQ-016 DROP_PACKET: stay while pkt_valid=1; pkt_valid=0 (parity byte cycle) -> DECODE_ADDRESS; no writes.
REQ-017 soft_reset[cur_ch]=1 in any state except DECODE_ADDRESS and DROP_PACKET -> DECODE_ADDRESS next edge, overriding all transitions; soft_reset of other channels ignored.
REQ-018 Fifo_full/fifo_empty/soft_reset bits of non-selected channels SHALL not affect state after DECODE_ADDRESS.
REQ-019 Decodes (combinational from state): write_enb_reg=LOAD_DATA|LOAD_PARITY|LOAD_AFTER_FULL; detect_add=DECODE_ADDRESS; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; lfd_state=LOAD_FIRST_DATA; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR; drop_state=DROP_PACKET.
REQ-020 busy=1 in all states except DECODE_ADDRESS, LOAD_DATA, DROP_PACKET.
REQ-021 cur_ch changes only on a legal-address decode; held otherwise.

Reset
REQ-022 resetn=0 asynchronously forces state=DECODE_ADDRESS, cur_ch=0, wait counter=0, addr_err=0, timeout_err=0; thus detect_add=1, all other outputs 0.
REQ-023 Reset asserted mid-packet aborts immediately; first edge after release evaluates DECODE_ADDRESS.

Verification
REQ-024 Header addr 1, fifo_empty=3'b111, 4 payload cycles, pkt_valid drops -> states DECODE, LFD, LD x4, LP, CPE, DECODE; cur_ch=1; busy low only in DECODE/LD.
REQ-025 Header addr 2, fifo_empty[2]=0 for 5 cycles then 1 -> WAIT_TILL_EMPTY 5 cycles, then LFD; fifo_empty[0] toggling has no effect; no timeout_err.
REQ-026 WAIT_MAX=4, header addr 0, fifo_empty[0] held 0 -> timeout_err single pulse after 4 wait cycles, drop_state=1 until pkt_valid=0, then DECODE; write_enb_reg never 1.
REQ-027 NUM_CH=3, header addr 3 -> addr_err single pulse, DROP_PACKET, return to DECODE on pkt_valid=0.
REQ-028 In LOAD_DATA on ch 1 assert fifo_full[1] 3 cycles -> FFS x3, LAF, then LD (low_packet_valid=0) or LP (=1); fifo_full[0]/[2] pulses ignored.
REQ-029 soft_reset[1] during FFS on ch 1 -> DECODE next edge; soft_reset[2] ignored; resetn pulse mid-LD -> DECODE immediately, cur_ch=0.
